// File: rtl/ux607_uart_frac_br_gen_pkg.sv
// rtl/ux607_uart_frac_br_gen_pkg.sv - shared widths, limits and config types for the ux607 UART baud generator
package ux607_uart_pkg;

    localparam int OSR_MIN    = 3;
    localparam int DIV_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;
    localparam int OSR_W_DEF  = 5;

    typedef logic [DIV_W_DEF-1:0]  div_t;
    typedef logic [FRAC_W_DEF-1:0] frac_t;
    typedef logic [OSR_W_DEF-1:0]  osr_t;

endpackage

// File: rtl/ux607_uart_frac_br_gen_if.sv
// rtl/ux607_uart_frac_br_gen_if.sv - config/strobe bundle between the UART core and the baud generator
interface ux607_uart_frac_br_gen_if
    import ux607_uart_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OSR_W  = OSR_W_DEF
);

    logic              baud_en;
    logic [DIV_W-1:0]  divisor;
    logic [FRAC_W-1:0] frac;
    logic [OSR_W-1:0]  osr;
    logic              rx_resync;
    logic              rx_data_sample;
    logic              rx_mid_sample;
    logic              tx_data_sample;
    logic              cfg_err;

    modport master (
        output baud_en, divisor, frac, osr, rx_resync,
        input  rx_data_sample, rx_mid_sample, tx_data_sample, cfg_err
    );

    modport slave (
        input  baud_en, divisor, frac, osr, rx_resync,
        output rx_data_sample, rx_mid_sample, tx_data_sample, cfg_err
    );

endinterface

// File: rtl/ux607_uart_frac_br_gen_prescaler.sv
// rtl/ux607_uart_frac_br_gen_prescaler.sv - shadowed integer/fractional prescaler producing the oversample tick
// Fractional accumulator is built only when UX607_UART_BR_FRAC_EN is defined.
module ux607_uart_br_prescaler
    import ux607_uart_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_baud_en,
    input  logic [DIV_W-1:0]  i_divisor,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              o_tick
);

    logic [DIV_W-1:0] r_div_s;
    logic [DIV_W:0]   r_pcnt;
    logic             r_tick;
    logic [DIV_W:0]   w_term;
    logic             w_wrap;

`ifdef UX607_UART_BR_FRAC_EN
    logic [FRAC_W-1:0] r_frac_s;
    logic [FRAC_W-1:0] r_acc;
    logic              r_carry;
    logic [FRAC_W:0]   w_acc_sum;

    // A carry out of the accumulator stretches the following period by one clock.
    assign w_term    = {1'b0, r_div_s} + {{DIV_W{1'b0}}, r_carry};
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frac_s <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
        end else if (!i_baud_en) begin
            r_frac_s <= i_frac;
            r_acc    <= '0;
            r_carry  <= 1'b0;
        end else if (w_wrap) begin
            r_acc    <= w_acc_sum[FRAC_W-1:0];
            r_carry  <= w_acc_sum[FRAC_W];
        end
    end
`else
    logic w_frac_unused;

    assign w_term        = {1'b0, r_div_s};
    assign w_frac_unused = ^i_frac;
`endif

    assign w_wrap = (r_pcnt == w_term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_s <= '0;
            r_pcnt  <= '0;
            r_tick  <= 1'b0;
        end else if (!i_baud_en) begin
            r_div_s <= i_divisor;
            r_pcnt  <= '0;
            r_tick  <= 1'b0;
        end else if (w_wrap) begin
            r_pcnt  <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_pcnt  <= r_pcnt + {{DIV_W{1'b0}}, 1'b1};
            r_tick  <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/ux607_uart_frac_br_gen.sv
// rtl/ux607_uart_frac_br_gen.sv - UART baud generator: oversample tick, TX bit strobe, re-phasable RX mid-bit strobe
// Optional fractional divide selected by UX607_UART_BR_FRAC_EN (see prescaler).
module ux607_uart_frac_br_gen
    import ux607_uart_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OSR_W  = OSR_W_DEF
) (
    input logic                     clk,
    input logic                     rst_n,
    ux607_uart_frac_br_gen_if.slave bus
);

    localparam logic [OSR_W-1:0] OSR_MIN_V = OSR_W'(OSR_MIN);

    logic             w_tick;
    logic [OSR_W-1:0] r_osr_s;
    logic             r_cfg_err;
    logic [OSR_W-1:0] r_tcnt;
    logic [OSR_W-1:0] r_rcnt;
    logic             r_tx;
    logic             r_mid;
    logic [OSR_W-1:0] w_osr_eff;
    logic [OSR_W-1:0] w_mid_pt;

    ux607_uart_br_prescaler #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_baud_en (bus.baud_en),
        .i_divisor (bus.divisor),
        .i_frac    (bus.frac),
        .o_tick    (w_tick)
    );

    // Too-small ratios are clamped so a bit always has a distinct centre tick.
    assign w_osr_eff = (r_osr_s < OSR_MIN_V) ? OSR_MIN_V : r_osr_s;
    assign w_mid_pt  = w_osr_eff >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_osr_s   <= '0;
            r_cfg_err <= 1'b0;
        end else if (!bus.baud_en) begin
            r_osr_s   <= bus.osr;
            r_cfg_err <= (bus.osr < OSR_MIN_V);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
            r_tx   <= 1'b0;
        end else if (!bus.baud_en) begin
            r_tcnt <= '0;
            r_tx   <= 1'b0;
        end else begin
            r_tx <= 1'b0;
            if (w_tick) begin
                if (r_tcnt == w_osr_eff) begin
                    r_tcnt <= '0;
                    r_tx   <= 1'b1;
                end else begin
                    r_tcnt <= r_tcnt + {{(OSR_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Resync wins over a coincident tick: that tick neither advances nor strobes RX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rcnt <= '0;
            r_mid  <= 1'b0;
        end else if (!bus.baud_en) begin
            r_rcnt <= '0;
            r_mid  <= 1'b0;
        end else if (bus.rx_resync) begin
            r_rcnt <= '0;
            r_mid  <= 1'b0;
        end else begin
            r_mid <= w_tick && (r_rcnt == w_mid_pt);
            if (w_tick) begin
                r_rcnt <= (r_rcnt == w_osr_eff) ? '0 : r_rcnt + {{(OSR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.rx_data_sample = w_tick;
    assign bus.rx_mid_sample  = r_mid;
    assign bus.tx_data_sample = r_tx;
    assign bus.cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_ux607_uart_frac_br_gen.sv
// tb/tb_ux607_uart_frac_br_gen.sv - scoreboard bench for ux607_uart_frac_br_gen (honours UX607_UART_BR_FRAC_EN)
module tb_ux607_uart_frac_br_gen;
    import ux607_uart_pkg::*;

    localparam int DW = DIV_W_DEF;
    localparam int FW = FRAC_W_DEF;
    localparam int OW = OSR_W_DEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ux607_uart_frac_br_gen_if #(.DIV_W(DW), .FRAC_W(FW), .OSR_W(OW)) bus ();

    ux607_uart_frac_br_gen #(.DIV_W(DW), .FRAC_W(FW), .OSR_W(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic exp_cfg = 1'b0;
    int   q_tick[$];
    int   q_tx[$];
    int   q_mid[$];

    always @(posedge clk) cyc++;

    task automatic cmp(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever one is due and checks any strobe seen or due.
    always @(negedge clk) begin
        logic e_tick, e_tx, e_mid;
        if (rst_n) begin
            e_tick = (q_tick.size() > 0) && (q_tick[0] == cyc);
            e_tx   = (q_tx.size() > 0) && (q_tx[0] == cyc);
            e_mid  = (q_mid.size() > 0) && (q_mid[0] == cyc);
            if (e_tick) void'(q_tick.pop_front());
            if (e_tx)   void'(q_tx.pop_front());
            if (e_mid)  void'(q_mid.pop_front());
            if (bus.rx_data_sample || e_tick) cmp("rx_data_sample", bus.rx_data_sample, e_tick);
            if (bus.tx_data_sample || e_tx)   cmp("tx_data_sample", bus.tx_data_sample, e_tx);
            if (bus.rx_mid_sample || e_mid)   cmp("rx_mid_sample", bus.rx_mid_sample, e_mid);
            cmp("cfg_err", bus.cfg_err, exp_cfg);
        end
    end

    // Tick k after enable lands at k whole periods plus the accumulated fractional clocks so far.
    function automatic int tick_time(input int n0, input int k, input int d, input int fe);
        return n0 + k * (d + 1) + (((k - 1) * fe) >> FW);
    endfunction

    task automatic run(input int d, input int f, input int o, input int len,
                       input int rs_mode, input bit do_rst);
        int n0, oe, c, t, kk, m, fe, rst_at;
        int tk[$];
`ifdef UX607_UART_BR_FRAC_EN
        fe = f;
`else
        fe = 0;
`endif
        bus.baud_en   = 1'b0;
        bus.divisor   = DW'(d);
        bus.frac      = FW'(f);
        bus.osr       = OW'(o);
        bus.rx_resync = 1'b0;
        @(posedge clk); #2;
        exp_cfg      = (o < OSR_MIN);
        n0           = cyc;
        bus.baud_en  = 1'b1;
        oe           = (o < OSR_MIN) ? OSR_MIN : o;

        kk = 1;
        t  = tick_time(n0, kk, d, fe);
        while (t <= n0 + len) begin
            tk.push_back(t);
            kk++;
            t = tick_time(n0, kk, d, fe);
        end

        case (rs_mode)
            1:       c = n0 + 1 + $urandom_range(len / 2);
            2:       c = tk[$urandom_range(tk.size() / 2)];
            default: c = -1;
        endcase
        rst_at = do_rst ? tk[tk.size() / 2] : -1;

        m = 0;
        foreach (tk[i]) begin
            kk = i + 1;
            t  = tk[i];
            q_tick.push_back(t);
            if ((kk % (oe + 1)) == 0 && t + 1 <= n0 + len) q_tx.push_back(t + 1);
            if (t < c) begin
                if (((kk - 1) % (oe + 1)) == oe / 2 && t + 1 <= n0 + len) q_mid.push_back(t + 1);
            end else if (t > c) begin
                m++;
                if (((m - 1) % (oe + 1)) == oe / 2 && t + 1 <= n0 + len) q_mid.push_back(t + 1);
            end
        end

        while (cyc < n0 + len) begin
            bus.rx_resync = (cyc == c);
            if ($urandom_range(7) == 0) begin
                bus.divisor = DW'($urandom_range(20));
                bus.frac    = FW'($urandom_range(15));
                bus.osr     = OW'($urandom_range(31));
            end
            if (cyc == rst_at) begin
                #1;
                rst_n = 1'b0;
                q_tick.delete();
                q_tx.delete();
                q_mid.delete();
                exp_cfg = 1'b0;
                #1;
                cmp("rst_rx_data_sample", bus.rx_data_sample, 1'b0);
                cmp("rst_tx_data_sample", bus.tx_data_sample, 1'b0);
                cmp("rst_rx_mid_sample", bus.rx_mid_sample, 1'b0);
                cmp("rst_cfg_err", bus.cfg_err, 1'b0);
                bus.baud_en   = 1'b0;
                bus.rx_resync = 1'b0;
                repeat (2) begin
                    @(posedge clk); #2;
                end
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #2;
        end
        bus.rx_resync = 1'b0;
        bus.baud_en   = 1'b0;
        bus.divisor   = DW'(d);
        bus.frac      = FW'(f);
        bus.osr       = OW'(o);
    endtask

    initial begin
        bus.baud_en   = 1'b0;
        bus.divisor   = '0;
        bus.frac      = '0;
        bus.osr       = '0;
        bus.rx_resync = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        cmp("reset_rx_data_sample", bus.rx_data_sample, 1'b0);
        cmp("reset_tx_data_sample", bus.tx_data_sample, 1'b0);
        cmp("reset_rx_mid_sample", bus.rx_mid_sample, 1'b0);
        cmp("reset_cfg_err", bus.cfg_err, 1'b0);
        rst_n = 1'b1;

        run(4, 0, 15, 200, 0, 1'b0);
        run(4, 8, 15, 200, 0, 1'b0);
        run(2, 0, 15, 300, 1, 1'b0);
        run(3, 5, 15, 300, 2, 1'b0);
        run(4, 0, 15, 60, 0, 1'b0);
        run(9, 0, 15, 120, 0, 1'b0);
        run(3, 0, 1, 100, 0, 1'b0);
        run(3, 0, 3, 100, 0, 1'b0);
        run(0, 0, 15, 60, 1, 1'b0);
        run(5, 3, 7, 200, 1, 1'b1);
        run(6, 0, 15, 120, 0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            run($urandom_range(12), $urandom_range(15), $urandom_range(31),
                $urandom_range(250, 40), $urandom_range(2), 1'b0);
        end
        repeat (5) begin
            @(posedge clk); #2;
        end
        cmp("queues_drained", (q_tick.size() + q_tx.size() + q_mid.size()) == 0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ux607_uart_frac_br_gen.md
# ux607_uart_frac_br_gen

Next-generation UART baud-rate generator for the ux607 peripheral subsystem. It divides the system clock by a 16-bit integer divisor plus an optional fractional part to produce an oversample tick. The oversampling ratio is programmable. It produces two bit strobes from the tick: a free-running TX bit strobe, and an RX mid-bit strobe that the receiver can re-phase on a start-bit edge.

## Interface
Parameters:
- DIV_W, 16, integer divisor width
- FRAC_W, 4, fractional divisor width (units of 1/2^FRAC_W clock)
- OSR_W, 5, oversample-ratio field width

Ports (clock is `clk`; reset is `rst_n`, asynchronous, active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- baud_en  in  1  generator enable; low = idle, counters cleared, config shadows load
- divisor  in  DIV_W  integer divide; tick period = divisor+1 clocks
- frac  in  FRAC_W  fractional divide addend
- osr  in  OSR_W  ticks per bit minus 1 (15 = 16x oversampling)
- rx_resync  in  1  one-cycle pulse from RX start-bit detect; re-phases RX counter
- rx_data_sample  out  1  one-cycle oversample tick
- rx_mid_sample  out  1  one-cycle pulse at RX bit centre
- tx_data_sample  out  1  one-cycle pulse per TX bit period
- cfg_err  out  1  registered flag: shadowed osr < 3

## Operation
- Shadows: in every cycle with baud_en=0, the block copies divisor/frac/osr into shadow registers. Shadows hold while baud_en=1, so mid-run input changes are ignored until the next disable/enable.
- Prescaler: pcnt counts 0..term. When pcnt==term: pcnt←0 and tick←1. Otherwise pcnt+1 and tick←0. rx_data_sample = tick (registered).
- term = divisor_s, or divisor_s+1 when the carry flag is set.
- Fractional accumulator: acc (FRAC_W bits). At each prescaler wrap, {carry,acc} ← acc+frac_s, and carry applies to the next period.
- Average tick period = divisor_s+1+frac_s/2^FRAC_W clocks.
- osr_eff = max(osr_s,3). cfg_err = (osr_s<3).
- TX counter: on each tick, if tcnt==osr_eff then tcnt←0 and tx_data_sample←1 (next cycle); otherwise tcnt+1.
- RX counter: on each tick, rcnt wraps 0..osr_eff. rx_mid_sample←1 when tick and rcnt==osr_eff>>1.
- rx_resync=1: rcnt←0 and any coincident tick is discarded for RX. Resync takes priority, and no rx_mid_sample is generated from that tick. rx_resync while baud_en=0 is ignored.
- baud_en=0 clears pcnt, acc, carry, tcnt and rcnt, and forces all strobes to 0 on the next edge.

## Timing
- Reset values: all outputs 0; pcnt, acc, carry, tcnt, rcnt = 0; shadows = 0.
- First rx_data_sample is high in the clock after the (divisor+1)-th enabled rising edge. With divisor=0, it is high every cycle.
- tx_data_sample and rx_mid_sample lag their qualifying tick by exactly 1 clock and never last longer than 1 clock.
- Counter wrap is modulo osr_eff+1. No overflow is possible: pcnt is DIV_W+1 bits wide to hold divisor+1.
- Reset asserted mid-operation: outputs drop asynchronously. After release, behaviour is identical to power-up.

## Configuration
- UX607_UART_BR_FRAC_EN defined: fractional accumulator present, behaviour as above.
- Macro undefined: acc and carry are removed, frac is ignored, and term = divisor_s always. Behaviour is then identical to a pure integer divider.

## Structure
- Package ux607_uart_pkg holds:
  - OSR_MIN=3.
  - Default DIV_W/FRAC_W/OSR_W.
  - The typedefs div_t, frac_t, osr_t.
- One sub-module, ux607_uart_br_prescaler, contains the shadowed integer/fractional prescaler and emits tick. The top module holds the TX/RX counters and cfg_err.

## Test plan
- divisor=4, frac=0, osr=15, baud_en=1 -> rx_data_sample every 5 clocks. tx_data_sample every 80 clocks, 1 clock after each 16th tick.
- Macro on, divisor=4, frac=8 -> tick periods alternate 5,6. Exactly 16 ticks in 88 clocks.
- osr=15, rx_resync pulsed at an arbitrary phase -> rx_mid_sample 1 clock after the 8th subsequent tick, then every 16 ticks. A resync coincident with a tick produces no mid pulse.
- Running with divisor=4, change divisor to 9 while enabled -> period stays 5. Drop baud_en for 1 cycle, then re-enable -> strobes 0 while low, then period 10.
- osr=1 -> cfg_err=1 and tx_data_sample every 4 ticks. osr=3 -> cfg_err=0.
- Assert rst_n low mid-bit -> all outputs 0 immediately. After release, the first tick comes divisor+1 enabled clocks later.
